// File: rtl/lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lock_ctrl
//  Brief    : Code-entry controller. Assembles keypad digits into an entry,
//             compares it against the password on '#', and drives the
//             Unlock / Error / Locked outputs with timed holds.
//  Options  : CHANGE_PW_EN - password held in a register that can be
//             rewritten from the OPEN state via '*' (SETPW state).
//  Revision : 1.0 - initial release
// ============================================================================
module lock_ctrl #(
  parameter int                  DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] PASSWORD    = 16'h1234,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  OPEN_CYCLES = 100,
  parameter int                  ERR_CYCLES  = 20,
  parameter int                  LOCK_CYCLES = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] Code,
  input  logic       Valid,
  output logic       Unlock,
  output logic       Error,
  output logic       Locked,
  output logic [3:0] Digit_cnt,
  output logic [2:0] Fails
);

  // Timer is sized for the longest of the three hold periods
  localparam int c_max_a   = (OPEN_CYCLES > ERR_CYCLES) ? OPEN_CYCLES : ERR_CYCLES;
  localparam int c_max_cyc = (c_max_a > LOCK_CYCLES) ? c_max_a : LOCK_CYCLES;
  localparam int c_tw      = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;
  localparam int c_bw      = 4 * DIGITS;

  localparam logic [c_tw-1:0] c_open_load = c_tw'(OPEN_CYCLES - 1);
  localparam logic [c_tw-1:0] c_err_load  = c_tw'(ERR_CYCLES - 1);
  localparam logic [c_tw-1:0] c_lock_load = c_tw'(LOCK_CYCLES - 1);
  localparam logic [2:0]      c_max_tries = 3'(MAX_TRIES);
  localparam logic [3:0]      c_digits    = 4'(DIGITS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_ERROR   = 3'd4,
    S_LOCKOUT = 3'd5
`ifdef CHANGE_PW_EN
    , S_SETPW = 3'd6
`endif
  } state_t;

  state_t            r_state;
  logic              r_valid_q;
  logic              r_valid_q2;
  logic [c_bw-1:0]   r_buf;
  logic [3:0]        r_cnt;
  logic [2:0]        r_fails;
  logic [c_tw-1:0]   r_timer;
  logic              r_unlock;
  logic              r_error;
  logic              r_locked;

  state_t            w_state_nxt;
  logic [c_bw-1:0]   w_buf_nxt;
  logic [3:0]        w_cnt_nxt;
  logic [2:0]        w_fails_nxt;
  logic [c_tw-1:0]   w_timer_nxt;
  logic [c_bw-1:0]   w_password;
  logic              w_unlock_nxt;

  logic              w_key_stb;
  logic              w_is_digit;
  logic              w_is_enter;
  logic              w_is_clear;
  logic              w_full;
  logic [c_bw-1:0]   w_buf_shift;
  logic [2:0]        w_fails_inc;
  logic              w_fail_locks;
  logic              w_timer_zero;

`ifdef CHANGE_PW_EN
  logic [c_bw-1:0]   r_pw;
  logic [c_bw-1:0]   w_pw_nxt;
  assign w_password = r_pw;
`else
  assign w_password = PASSWORD;
`endif

  // One strobe per Valid rising edge; Code is aligned with the strobe cycle
  assign w_key_stb    = r_valid_q & ~r_valid_q2;
  assign w_is_digit   = w_key_stb && (Code <= 4'd9);
  assign w_is_enter   = w_key_stb && (Code == 4'd10);
  assign w_is_clear   = w_key_stb && (Code == 4'd11);

  assign w_full       = (r_cnt == c_digits);
  assign w_buf_shift  = (r_buf << 4) | c_bw'(Code);
  assign w_fails_inc  = r_fails + 3'd1;
  assign w_fail_locks = (w_fails_inc == c_max_tries);
  assign w_timer_zero = (r_timer == '0);

  // Next-state, datapath and output decode for the controller
  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_fails_nxt = r_fails;
    w_timer_nxt = r_timer;
`ifdef CHANGE_PW_EN
    w_pw_nxt    = r_pw;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_is_digit) begin
          w_buf_nxt   = w_buf_shift;
          w_cnt_nxt   = 4'd1;
          w_state_nxt = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (w_is_digit) begin
          if (!w_full) begin
            w_buf_nxt = w_buf_shift;
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end else if (w_is_clear) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_IDLE;
        end else if (w_is_enter) begin
          if (w_full) begin
            w_state_nxt = S_CHECK;
          end else begin
            // A short entry counts as a failed attempt
            w_buf_nxt   = '0;
            w_cnt_nxt   = 4'd0;
            w_fails_nxt = w_fails_inc;
            w_state_nxt = w_fail_locks ? S_LOCKOUT : S_ERROR;
            w_timer_nxt = w_fail_locks ? c_lock_load : c_err_load;
          end
        end
      end
      S_CHECK: begin
        w_buf_nxt = '0;
        w_cnt_nxt = 4'd0;
        if (r_buf == w_password) begin
          w_fails_nxt = 3'd0;
          w_state_nxt = S_OPEN;
          w_timer_nxt = c_open_load;
        end else begin
          w_fails_nxt = w_fails_inc;
          w_state_nxt = w_fail_locks ? S_LOCKOUT : S_ERROR;
          w_timer_nxt = w_fail_locks ? c_lock_load : c_err_load;
        end
      end
      S_OPEN: begin
        // Expiry wins over any key arriving in the same cycle
        if (w_timer_zero) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
          if (w_is_enter) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
          end
`ifdef CHANGE_PW_EN
          else if (w_is_clear) begin
            w_state_nxt = S_SETPW;
            w_timer_nxt = r_timer;
          end
`endif
        end
      end
      S_ERROR: begin
        if (w_timer_zero) w_state_nxt = S_IDLE;
        else              w_timer_nxt = r_timer - 1'b1;
      end
      S_LOCKOUT: begin
        if (w_timer_zero) begin
          w_state_nxt = S_IDLE;
          w_fails_nxt = 3'd0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
`ifdef CHANGE_PW_EN
      S_SETPW: begin
        if (w_is_digit) begin
          if (!w_full) begin
            w_buf_nxt = w_buf_shift;
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end else if (w_is_clear) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = 4'd0;
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (w_is_enter) begin
          w_buf_nxt = '0;
          w_cnt_nxt = 4'd0;
          if (w_full) begin
            w_pw_nxt    = r_buf;
            w_timer_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_timer_nxt = c_err_load;
            w_state_nxt = S_ERROR;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_buf_nxt   = '0;
        w_cnt_nxt   = 4'd0;
        w_timer_nxt = '0;
      end
    endcase

    w_unlock_nxt = (w_state_nxt == S_OPEN);
`ifdef CHANGE_PW_EN
    if (w_state_nxt == S_SETPW) w_unlock_nxt = 1'b1;
`endif
  end

  // State, datapath and registered output update
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_valid_q  <= 1'b0;
      r_valid_q2 <= 1'b0;
      r_buf      <= '0;
      r_cnt      <= 4'd0;
      r_fails    <= 3'd0;
      r_timer    <= '0;
      r_unlock   <= 1'b0;
      r_error    <= 1'b0;
      r_locked   <= 1'b0;
`ifdef CHANGE_PW_EN
      r_pw       <= PASSWORD;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_valid_q  <= Valid;
      r_valid_q2 <= r_valid_q;
      r_buf      <= w_buf_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fails    <= w_fails_nxt;
      r_timer    <= w_timer_nxt;
      r_unlock   <= w_unlock_nxt;
      r_error    <= (w_state_nxt == S_ERROR);
      r_locked   <= (w_state_nxt == S_LOCKOUT);
`ifdef CHANGE_PW_EN
      r_pw       <= w_pw_nxt;
`endif
    end
  end

  assign Unlock    = r_unlock;
  assign Error     = r_error;
  assign Locked    = r_locked;
  assign Digit_cnt = r_cnt;
  assign Fails     = r_fails;

endmodule
`default_nettype wire

// File: tb/tb_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lock_ctrl
//  Brief    : Self-checking bench for lock_ctrl. A behavioural model tracks
//             the entered digits as a queue and the timed phases as
//             remaining-cycle counts; outputs are compared every cycle.
//  Options  : CHANGE_PW_EN - enables the password-change scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lock_ctrl;

  localparam int          D     = 4;
  localparam logic [15:0] PW    = 16'h1234;
  localparam int          MAXT  = 3;
  localparam int          OPENC = 100;
  localparam int          ERRC  = 20;
  localparam int          LOCKC = 500;

  bit         clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [3:0] code;
  logic       unlock;
  logic       err;
  logic       locked;
  logic [3:0] dcnt;
  logic [2:0] fails;

  // Free-running clock
  always #5 clk = ~clk;

  lock_ctrl #(
    .DIGITS(D), .PASSWORD(PW), .MAX_TRIES(MAXT),
    .OPEN_CYCLES(OPENC), .ERR_CYCLES(ERRC), .LOCK_CYCLES(LOCKC)
  ) dut (
    .clock(clk), .reset(rst), .Code(code), .Valid(valid),
    .Unlock(unlock), .Error(err), .Locked(locked),
    .Digit_cnt(dcnt), .Fails(fails)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_unlock, cnt_err, cnt_lock;

  // Behavioural model: digit queue, remaining-cycle counters, flags
  bit m_vq, m_vq2;
  int m_q[$];
  int m_pw[D];
  int m_fails, m_open, m_err, m_lock;
  bit m_check, m_setpw;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit model_match();
    for (int i = 0; i < D; i++) if (m_q[i] != m_pw[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_fail();
    m_fails++;
    if (m_fails == MAXT) m_lock = LOCKC;
    else                 m_err  = ERRC;
  endtask

  // Advance the model across one rising edge with the given inputs
  task automatic model_step(input bit r, input bit v, input int c);
    bit stb, dig, ent, clr;
    int pwi;
    if (r) begin
      m_vq = 0; m_vq2 = 0; m_q.delete();
      m_fails = 0; m_open = 0; m_err = 0; m_lock = 0;
      m_check = 0; m_setpw = 0;
      pwi = int'(PW);
      for (int i = 0; i < D; i++) m_pw[i] = (pwi >> (4 * (D - 1 - i))) & 15;
      return;
    end
    stb = m_vq && !m_vq2;
    m_vq2 = m_vq;
    m_vq  = v;
    dig = stb && (c <= 9);
    ent = stb && (c == 10);
    clr = stb && (c == 11);
    if (m_check) begin
      m_check = 0;
      if (model_match()) begin m_fails = 0; m_open = OPENC; end
      else model_fail();
      m_q.delete();
    end else if (m_open > 0) begin
      if (m_open == 1) m_open = 0;
      else begin
        m_open--;
        if (ent) m_open = 0;
`ifdef CHANGE_PW_EN
        else if (clr) begin m_open = 0; m_setpw = 1; end
`endif
      end
    end else if (m_err > 0) begin
      m_err--;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_setpw) begin
      if (dig) begin
        if (m_q.size() < D) m_q.push_back(c);
      end else if (clr) begin
        m_setpw = 0; m_q.delete();
      end else if (ent) begin
        if (m_q.size() == D) for (int i = 0; i < D; i++) m_pw[i] = m_q[i];
        else m_err = ERRC;
        m_setpw = 0; m_q.delete();
      end
    end else begin
      if (dig) begin
        if (m_q.size() < D) m_q.push_back(c);
      end else if (clr) begin
        m_q.delete();
      end else if (ent && m_q.size() > 0) begin
        if (m_q.size() == D) m_check = 1;
        else begin model_fail(); m_q.delete(); end
      end
    end
  endtask

  // One clock: model the edge, then compare all outputs on the falling edge
  task automatic tick();
    model_step(rst, valid, int'(code));
    @(negedge clk);
    check("unlock", int'(unlock), int'((m_open > 0) || m_setpw));
    check("error",  int'(err),    int'(m_err > 0));
    check("locked", int'(locked), int'(m_lock > 0));
    check("digit_cnt", int'(dcnt), m_q.size());
    check("fails",  int'(fails),  m_fails);
    if (unlock) cnt_unlock++;
    if (err)    cnt_err++;
    if (locked) cnt_lock++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int k, input int hold = 2, input int gap = 2);
    code  = 4'(k);
    valid = 1'b1;
    repeat (hold) tick();
    valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d); press(10);
  endtask

  task automatic clr_counts();
    cnt_unlock = 0; cnt_err = 0; cnt_lock = 0;
  endtask

  // Directed scenarios followed by randomized key traffic
  initial begin
    int r;
    rst = 1'b1; valid = 1'b0; code = 4'd0;
    clr_counts();
    idle(3);
    rst = 1'b0;
    check("rst_unlock", int'(unlock), 0);
    check("rst_dcnt",   int'(dcnt),   0);
    check("rst_fails",  int'(fails),  0);

    // Correct code unlocks for the full open period
    clr_counts();
    enter4(1, 2, 3, 4);
    idle(110);
    check("t1_unlock_cycles", cnt_unlock, 100);
    check("t1_fails", int'(fails), 0);

    // Two wrong codes give error pulses, the third locks out
    clr_counts();
    enter4(1, 2, 3, 5); idle(25);
    check("t2_fails1", int'(fails), 1);
    check("t2_err_cycles1", cnt_err, 20);
    enter4(1, 2, 3, 5); idle(25);
    check("t2_fails2", int'(fails), 2);
    check("t2_err_cycles2", cnt_err, 40);
    clr_counts();
    enter4(9, 9, 9, 9); idle(3);
    check("t2_locked", int'(locked), 1);
    check("t2_fails3", int'(fails), 3);
    enter4(1, 2, 3, 4);
    idle(490);
    check("t2_lock_cycles", cnt_lock, 500);
    check("t2_lock_unlock", cnt_unlock, 0);
    check("t2_fails_clr", int'(fails), 0);

    // Clear mid-entry, then saturation of the entry buffer
    clr_counts();
    press(1); press(2);
    check("t3_dcnt2", int'(dcnt), 2);
    press(11);
    check("t3_dcnt0", int'(dcnt), 0);
    enter4(1, 2, 3, 4); idle(110);
    check("t3_unlock_a", cnt_unlock, 100);
    clr_counts();
    press(1); press(2); press(3); press(4); press(5);
    check("t3_dcnt_sat", int'(dcnt), 4);
    press(10); idle(110);
    check("t3_unlock_b", cnt_unlock, 100);

    // Short entry, held Valid, unused code
    press(1); press(2); press(10); idle(2);
    check("t4_err", int'(err), 1);
    check("t4_fails", int'(fails), 1);
    idle(25);
    press(7, 50, 2);
    check("t4_held", int'(dcnt), 1);
    press(13);
    check("t4_code13", int'(dcnt), 1);
    press(11);

    // Early relock from OPEN, then reset mid-entry
    enter4(1, 2, 3, 4); idle(10);
    press(10);
    check("t5_relock", int'(unlock), 0);
    press(9); press(9); press(10); idle(25);
    press(1); press(2); press(3);
    check("t5_dcnt3", int'(dcnt), 3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_rst_dcnt",  int'(dcnt),  0);
    check("t5_rst_fails", int'(fails), 0);
    check("t5_rst_err",   int'(err),   0);

`ifdef CHANGE_PW_EN
    // Password change and restore on reset
    enter4(1, 2, 3, 4); idle(5);
    press(11);
    check("t6_setpw_unlock", int'(unlock), 1);
    enter4(5, 6, 7, 8); idle(3);
    check("t6_setpw_done", int'(unlock), 0);
    enter4(1, 2, 3, 4); idle(3);
    check("t6_old_pw_err", int'(err), 1);
    idle(25);
    enter4(5, 6, 7, 8); idle(3);
    check("t6_new_pw_open", int'(unlock), 1);
    idle(110);
    rst = 1'b1; idle(2); rst = 1'b0;
    enter4(1, 2, 3, 4); idle(3);
    check("t6_pw_restored", int'(unlock), 1);
    idle(110);
`endif

    // Randomized traffic, occasionally entering the current password
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        for (int i = 0; i < D; i++) press(m_pw[i]);
        press(10);
      end else if (r == 1) begin
        rst = 1'b1; idle($urandom_range(1, 2)); rst = 1'b0;
      end else if (r == 2) begin
        idle($urandom_range(0, 40));
      end else begin
        press($urandom_range(0, 15), $urandom_range(1, 4), $urandom_range(1, 3));
      end
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
